// File: rtl/timer_bank_pkg.sv
// Shared register map, CTRL field positions and address layout for the timer bank.
package timer_bank_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 6;
  localparam int unsigned OFF_W  = 2;
  localparam int unsigned CH_W   = 4;

  // Register offsets within one channel's four-word window
  typedef enum logic [OFF_W-1:0] {
    REG_CTRL   = 2'd0,
    REG_PERIOD = 2'd1,
    REG_CNT    = 2'd2,
    REG_STATUS = 2'd3
  } reg_off_e;

  localparam int unsigned CTRL_EN_BIT       = 31;
  localparam int unsigned CTRL_ONE_SHOT_BIT = 30;
  localparam int unsigned CTRL_IRQ_EN_BIT   = 29;
  localparam int unsigned STATUS_FLAG_BIT   = 0;

endpackage

// File: rtl/timer_ch.sv
// One timer channel: CTRL/PERIOD/STATUS registers, prescaler, counter and sticky flag.
module timer_ch
  import timer_bank_pkg::*;
#(
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PSC_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [OFF_W-1:0]  off,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_c,
  output logic              ovf,
  output logic              irq_c
);

  logic             en_q, en_d;
  logic             one_shot_q, one_shot_d;
  logic             irq_en_q, irq_en_d;
  logic [PSC_W-1:0] scale_q, scale_d;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flag_q, flag_d;
  logic             ovf_q, ovf_d;
  logic             tick_c, wrap_c;
  logic             unused_wdata;

  // Field bits of wdata not mapped to any register are deliberately dropped
  assign unused_wdata = ^wdata;

  // Next-state: count, wrap, then apply any register write (write has the last word)
  always_comb begin
    en_d       = en_q;
    one_shot_d = one_shot_q;
    irq_en_d   = irq_en_q;
    scale_d    = scale_q;
    psc_d      = psc_q;
    period_d   = period_q;
    cnt_d      = cnt_q;
    flag_d     = flag_q;
    ovf_d      = 1'b0;
    // >= rather than == so a scale lowered below the running prescaler ticks at once
    tick_c     = en_q && (psc_q >= scale_q);
    wrap_c     = tick_c && (cnt_q >= period_q);

    if (en_q) begin
      psc_d = tick_c ? '0 : psc_q + PSC_W'(1);
    end
    if (tick_c) begin
      cnt_d = wrap_c ? '0 : cnt_q + CNT_W'(1);
    end
    if (wrap_c) begin
      ovf_d  = 1'b1;
      flag_d = 1'b1;
      if (one_shot_q) begin
        en_d = 1'b0;
      end
    end

    if (we) begin
      case (reg_off_e'(off))
        REG_CTRL: begin
          en_d       = wdata[CTRL_EN_BIT];
          one_shot_d = wdata[CTRL_ONE_SHOT_BIT];
          irq_en_d   = wdata[CTRL_IRQ_EN_BIT];
          scale_d    = wdata[PSC_W-1:0];
        end
        REG_PERIOD: period_d = wdata[CNT_W-1:0];
        REG_STATUS: begin
          // A wrap on the same edge keeps the flag set
          if (wdata[STATUS_FLAG_BIT] && !wrap_c) begin
            flag_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    // A stopped channel always restarts its count from zero
    if (!en_d) begin
      psc_d = '0;
      cnt_d = '0;
    end
  end

  // Channel state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      en_q       <= 1'b0;
      one_shot_q <= 1'b0;
      irq_en_q   <= 1'b0;
      scale_q    <= '0;
      psc_q      <= '0;
      period_q   <= '0;
      cnt_q      <= '0;
      flag_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      en_q       <= en_d;
      one_shot_q <= one_shot_d;
      irq_en_q   <= irq_en_d;
      scale_q    <= scale_d;
      psc_q      <= psc_d;
      period_q   <= period_d;
      cnt_q      <= cnt_d;
      flag_q     <= flag_d;
      ovf_q      <= ovf_d;
    end
  end

  // Register read view; unmapped bits read as zero
  always_comb begin
    rdata_c = '0;
    case (reg_off_e'(off))
      REG_CTRL: begin
        rdata_c[CTRL_EN_BIT]       = en_q;
        rdata_c[CTRL_ONE_SHOT_BIT] = one_shot_q;
        rdata_c[CTRL_IRQ_EN_BIT]   = irq_en_q;
        rdata_c[PSC_W-1:0]         = scale_q;
      end
      REG_PERIOD: rdata_c[CNT_W-1:0]       = period_q;
      REG_CNT:    rdata_c[CNT_W-1:0]       = cnt_q;
      REG_STATUS: rdata_c[STATUS_FLAG_BIT] = flag_q;
      default: ;
    endcase
  end

  assign ovf   = ovf_q;
  assign irq_c = flag_q & irq_en_q;

endmodule

// File: rtl/timer_bank.sv
// Bank of N_CH independent timer channels behind a small word-addressed register file.
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned PSC_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [N_CH-1:0]   ovf,
  output logic              irq
);

  logic [CH_W-1:0]   ch_idx;
  logic [OFF_W-1:0]  off;
  logic [DATA_W-1:0] ch_rdata [N_CH];
  logic [N_CH-1:0]   ch_irq;
  logic              irq_q, irq_d;

  assign ch_idx = addr[ADDR_W-1:OFF_W];
  assign off    = addr[OFF_W-1:0];

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    timer_ch #(
      .CNT_W (CNT_W),
      .PSC_W (PSC_W)
    ) u_ch (
      .clk     (clk),
      .reset   (reset),
      .we      (we && (ch_idx == CH_W'(g))),
      .off     (off),
      .wdata   (wdata),
      .rdata_c (ch_rdata[g]),
      .ovf     (ovf[g]),
      .irq_c   (ch_irq[g])
    );
  end

  // Read mux; channel indices beyond N_CH match nothing and read zero
  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (ch_idx == CH_W'(i)) begin
        rdata = ch_rdata[i];
      end
    end
  end

  // Interrupt request: any channel with flag and irq_en
  always_comb begin
    irq_d = |ch_irq;
  end

  // Interrupt output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq = irq_q;

endmodule
